// File: rtl/ebi_pkg.sv
// Shared constants and types for the EBI receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ebi_pkg;

    localparam int PARITY_LENGTH = 8;   // data slots covered by each even-parity bit
    localparam int CREDIT_LENGTH = 2;   // credit code bits after the credit start bit

    typedef logic [CREDIT_LENGTH-1:0] credit_t;

    localparam credit_t SUCCESS = 2'b01;
    localparam credit_t FAIL    = 2'b10;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_END,
        RX_CRED_START,
        RX_CRED_BITS
    } rx_state_t;

    // Channel ids wider than the channel count are possible on the wire.
    function automatic logic chan_ok(input int unsigned id, input int unsigned num);
        return id < num;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ebi_credit_ser.sv
// Credit serializer: one start bit (0) then the credit code LSB first, line idles high.
// Latency: start bit appears the cycle after load; code bits follow on the next CREDIT_LENGTH cycles.
// Backpressure: load is ignored while busy; the caller waits for busy to drop.
//
// Ports: clk, rstn (sync, active low), load/code (request a credit frame),
//        busy (shifter still owns the line), credit_out (serial credit line).
module ebi_credit_ser
    import ebi_pkg::*;
(
    input  logic    clk,
    input  logic    rstn,
    input  logic    load,
    input  credit_t code,
    output logic    busy,
    output logic    credit_out
);

    localparam int CNT_W = $clog2(CREDIT_LENGTH + 1);

    logic [CNT_W-1:0] cnt;
    credit_t          shreg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt        <= '0;
            shreg      <= '0;
            credit_out <= 1'b1;
        end else if (load && !busy) begin
            credit_out <= 1'b0;
            shreg      <= code;
            cnt        <= CNT_W'(CREDIT_LENGTH);
        end else if (busy) begin
            credit_out <= shreg[0];
            shreg      <= shreg >> 1;
            cnt        <= cnt - CNT_W'(1);
        end else begin
            credit_out <= 1'b1;
        end
    end

    // Drops while the last code bit is still on the line; the line returns high on the next edge.
    assign busy = (cnt != '0);

endmodule

// File: rtl/ebi_rx_deser.sv
// EBI receive deserializer: samples the serial frame, checks parity/framing, delivers message, returns credit.
// Latency: message valid and credit start bit both appear the cycle after the end bit is sampled.
// Backpressure: msg_valid_o holds until msg_ready_i; a frame ending while the output is occupied is refused (FAIL credit).
//
// Ports: clk, rstn (sync, active low), bus_in (serial frame, idle high), credit_out (serial credit, idle high),
//        msg_valid_o/msg_ready_i/msg_chan_o/msg_payload_o (message port, payload LSB aligned, upper bits zero).
// Optional build macro EBI_RX_ERR_CNT_EN adds saturating parity_err_cnt_o, frame_err_cnt_o, overflow_cnt_o.
module ebi_rx_deser
    import ebi_pkg::*;
#(
    parameter int CHANNEL_NUM        = 4,
    parameter int CHANNEL_NUM_WIDTH  = 2,
    parameter int MAX_MESSAGE_LENGTH = 32,
    parameter int MAX_MESSAGE_WIDTH  = 6,
    parameter int CHANNEL_LENGTH_LIST [CHANNEL_NUM] = '{8, 16, 24, 32}
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          bus_in,
    output logic                          credit_out,
    output logic                          msg_valid_o,
    input  logic                          msg_ready_i,
    output logic [CHANNEL_NUM_WIDTH-1:0]  msg_chan_o,
    output logic [MAX_MESSAGE_LENGTH-1:0] msg_payload_o
`ifdef EBI_RX_ERR_CNT_EN
    ,
    output logic [15:0]                   parity_err_cnt_o,
    output logic [15:0]                   frame_err_cnt_o,
    output logic [15:0]                   overflow_cnt_o
`endif
);

    localparam int CW = CHANNEL_NUM_WIDTH;
    localparam int MW = MAX_MESSAGE_WIDTH;
    localparam int AW = CHANNEL_NUM_WIDTH + MAX_MESSAGE_LENGTH;
    localparam int GW = $clog2(PARITY_LENGTH);

    rx_state_t       state, state_nxt;
    logic [MW-1:0]   slot_cnt;      // data slots received so far in this frame
    logic [GW-1:0]   grp_cnt;       // position inside the current parity group
    logic            par_q;         // running parity of the current group
    logic            perr_q;        // sticky parity error for this frame
    logic [CW-1:0]   chan_q;
    logic [AW-1:0]   asm_q, asm_nxt; // id in the low bits, payload above
    logic [MW-1:0]   frame_len, slot_total;
    logic            id_ok, ferr, accept;
    logic            cred_load, cred_busy;
    credit_t         cred_code;

    assign id_ok = chan_ok(32'(chan_q), CHANNEL_NUM);

    // A bad id shrinks the frame to one payload bit so the transmitter cannot run the counter away.
    always_comb begin
        frame_len  = id_ok ? MW'(CHANNEL_LENGTH_LIST[chan_q] + CW) : MW'(CW + 1);
        slot_total = (frame_len + MW'(PARITY_LENGTH - 1)) & ~MW'(PARITY_LENGTH - 1);
    end

    // Pad slots past the real frame length are not stored, so the payload stays zero-extended.
    always_comb begin
        asm_nxt = asm_q;
        if (slot_cnt < frame_len) asm_nxt[slot_cnt] = bus_in;
    end

    // Only meaningful in RX_END, where bus_in carries the end bit.
    assign ferr      = !bus_in;
    assign accept    = !perr_q && !ferr && id_ok && !msg_valid_o;
    assign cred_code = accept ? SUCCESS : FAIL;

    always_ff @(posedge clk) begin
        if (!rstn) state <= RX_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cred_load = 1'b0;
        case (state)
            RX_IDLE:       if (!bus_in) state_nxt = RX_DATA;
            RX_DATA:       if (grp_cnt == GW'(PARITY_LENGTH - 1)) state_nxt = RX_PARITY;
            RX_PARITY:     state_nxt = (slot_cnt == slot_total) ? RX_END : RX_DATA;
            RX_END: begin
                cred_load = 1'b1;
                state_nxt = RX_CRED_START;
            end
            RX_CRED_START: state_nxt = RX_CRED_BITS;
            RX_CRED_BITS:  if (!cred_busy) state_nxt = RX_IDLE;
            default:       state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slot_cnt <= '0;
            grp_cnt  <= '0;
            par_q    <= 1'b0;
            perr_q   <= 1'b0;
            chan_q   <= '0;
            asm_q    <= '0;
        end else begin
            case (state)
                RX_IDLE: begin
                    // Re-arm every idle cycle so the next frame starts from a clean slate.
                    slot_cnt <= '0;
                    grp_cnt  <= '0;
                    par_q    <= 1'b0;
                    perr_q   <= 1'b0;
                    chan_q   <= '0;
                    asm_q    <= '0;
                end
                RX_DATA: begin
                    asm_q    <= asm_nxt;
                    par_q    <= par_q ^ bus_in;
                    slot_cnt <= slot_cnt + MW'(1);
                    grp_cnt  <= grp_cnt + GW'(1);
                    if (slot_cnt == MW'(CW - 1)) chan_q <= asm_nxt[CW-1:0];
                end
                RX_PARITY: begin
                    if (bus_in != par_q) perr_q <= 1'b1;
                    par_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            msg_valid_o   <= 1'b0;
            msg_chan_o    <= '0;
            msg_payload_o <= '0;
        end else if (state == RX_END && accept) begin
            msg_valid_o   <= 1'b1;
            msg_chan_o    <= chan_q;
            msg_payload_o <= asm_q[AW-1:CW];
        end else if (msg_valid_o && msg_ready_i) begin
            msg_valid_o   <= 1'b0;
        end
    end

`ifdef EBI_RX_ERR_CNT_EN
    // One count per refused frame, most specific cause wins.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            parity_err_cnt_o <= '0;
            frame_err_cnt_o  <= '0;
            overflow_cnt_o   <= '0;
        end else if (state == RX_END) begin
            if (perr_q)       parity_err_cnt_o <= sat_inc16(parity_err_cnt_o);
            else if (ferr)    frame_err_cnt_o  <= sat_inc16(frame_err_cnt_o);
            else if (!accept) overflow_cnt_o   <= sat_inc16(overflow_cnt_o);
        end
    end
`endif

    ebi_credit_ser u_credit_ser (
        .clk        (clk),
        .rstn       (rstn),
        .load       (cred_load),
        .code       (cred_code),
        .busy       (cred_busy),
        .credit_out (credit_out)
    );

endmodule

// File: tb/tb_ebi_rx_deser.sv
// Directed bench for ebi_rx_deser: table of single frames plus overflow, back-to-back and reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_ebi_rx_deser;

    logic        clk;
    logic        rstn;
    logic        bus_in;
    logic        credit_out;
    logic        msg_valid_o;
    logic        msg_ready_i;
    logic [1:0]  msg_chan_o;
    logic [31:0] msg_payload_o;
`ifdef EBI_RX_ERR_CNT_EN
    logic [15:0] parity_err_cnt_o, frame_err_cnt_o, overflow_cnt_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    int len_list [4] = '{8, 16, 24, 32};
    bit frame_q [$];

    ebi_rx_deser dut (
        .clk           (clk),
        .rstn          (rstn),
        .bus_in        (bus_in),
        .credit_out    (credit_out),
        .msg_valid_o   (msg_valid_o),
        .msg_ready_i   (msg_ready_i),
        .msg_chan_o    (msg_chan_o),
        .msg_payload_o (msg_payload_o)
`ifdef EBI_RX_ERR_CNT_EN
        ,
        .parity_err_cnt_o (parity_err_cnt_o),
        .frame_err_cnt_o  (frame_err_cnt_o),
        .overflow_cnt_o   (overflow_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end (n_fail=%0d)", n_fail);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Independent frame model: id then payload LSB first, pad by repeating the last bit,
    // even parity after each 8 slots; flip_par selects one parity bit to corrupt.
    task automatic build_frame(input int ch, input logic [31:0] pl, input int flip_par,
                               input bit end_bit, input bit with_start);
        bit d [$];
        bit p;
        int len, slots;
        frame_q.delete();
        len   = len_list[ch];
        slots = ((len + 2 + 7) / 8) * 8;
        for (int i = 0; i < 2; i++)   d.push_back(ch[i]);
        for (int i = 0; i < len; i++) d.push_back(pl[i]);
        while (d.size() < slots) d.push_back(d[d.size()-1]);
        if (with_start) frame_q.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < slots; i++) begin
            frame_q.push_back(d[i]);
            p ^= d[i];
            if (i % 8 == 7) begin
                if (flip_par == i / 8) p = ~p;
                frame_q.push_back(p);
                p = 1'b0;
            end
        end
        frame_q.push_back(end_bit);
    endtask

    task automatic send_frame(input bit raise_ready_last);
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk);
            bus_in = frame_q[i];
            if (raise_ready_last && i == frame_q.size() - 1) msg_ready_i = 1'b1;
        end
    endtask

    // Called right after the end bit has been driven.
    task automatic get_credit(input string nm, input logic [1:0] code, input bit vld,
                              input logic [1:0] ch, input logic [31:0] pl, input bit vld2,
                              input bit noise, input bit b2b);
        @(negedge clk);
        chk($sformatf("%s.cred_start", nm), 64'(credit_out), 64'd0);
        chk($sformatf("%s.valid", nm), 64'(msg_valid_o), 64'(vld));
        if (vld) begin
            chk($sformatf("%s.chan", nm), 64'(msg_chan_o), 64'(ch));
            chk($sformatf("%s.payload", nm), 64'(msg_payload_o), 64'(pl));
        end
        bus_in = noise ? 1'b0 : 1'b1;
        @(negedge clk);
        chk($sformatf("%s.cred_b0", nm), 64'(credit_out), 64'(code[0]));
        chk($sformatf("%s.valid_next", nm), 64'(msg_valid_o), 64'(vld2));
        @(negedge clk);
        chk($sformatf("%s.cred_b1", nm), 64'(credit_out), 64'(code[1]));
        @(negedge clk);
        chk($sformatf("%s.cred_idle", nm), 64'(credit_out), 64'd1);
        bus_in = b2b ? 1'b0 : 1'b1;
    endtask

    typedef struct {
        int          ch;
        logic [31:0] pl;
        int          flip;
        bit          end_bit;
        bit          noise;
        logic [1:0]  code;
        bit          vld;
        logic [31:0] exp_pl;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{0, 32'hFFFF_12A5, -1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_00A5};
        vecs[1] = '{0, 32'h0000_00A5,  1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0};
        vecs[2] = '{1, 32'h0000_1234, -1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0};
        vecs[3] = '{3, 32'h89AB_CDEF, -1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h89AB_CDEF};
        vecs[4] = '{0, 32'h0000_005A, -1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_005A};
        vecs[5] = '{2, 32'h00C0_FFEE, -1, 1'b1, 1'b1, 2'b01, 1'b1, 32'h00C0_FFEE};
        vecs[6] = '{3, 32'h1357_9BDF,  0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0};
        vecs[7] = '{1, 32'hFFFF_BEEF, -1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_BEEF};

        rstn        = 1'b0;
        bus_in      = 1'b1;
        msg_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.credit", 64'(credit_out), 64'd1);
        chk("rst.valid", 64'(msg_valid_o), 64'd0);
        chk("rst.chan", 64'(msg_chan_o), 64'd0);
        chk("rst.payload", 64'(msg_payload_o), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            build_frame(vecs[v].ch, vecs[v].pl, vecs[v].flip, vecs[v].end_bit, 1'b1);
            send_frame(1'b0);
            get_credit($sformatf("vec%0d", v), vecs[v].code, vecs[v].vld, 2'(vecs[v].ch),
                       vecs[v].exp_pl, 1'b0, vecs[v].noise, 1'b0);
        end

        // Output held by a stalled consumer: later frames are refused without touching it.
        msg_ready_i = 1'b0;
        build_frame(3, 32'hDEAD_BEEF, -1, 1'b1, 1'b1);
        send_frame(1'b0);
        get_credit("ovf.first", 2'b01, 1'b1, 2'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        build_frame(1, 32'h0000_5555, -1, 1'b1, 1'b1);
        send_frame(1'b0);
        get_credit("ovf.second", 2'b10, 1'b1, 2'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        // Ready arrives in the same cycle the end bit is sampled: still refused, pending message drains.
        build_frame(0, 32'h0000_0011, -1, 1'b1, 1'b1);
        send_frame(1'b1);
        get_credit("ovf.collide", 2'b10, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0);

`ifdef EBI_RX_ERR_CNT_EN
        chk("cnt.parity", 64'(parity_err_cnt_o), 64'd2);
        chk("cnt.frame", 64'(frame_err_cnt_o), 64'd1);
        chk("cnt.overflow", 64'(overflow_cnt_o), 64'd2);
`endif

        // Back-to-back: second start bit lands in the first idle cycle after the credit.
        build_frame(2, 32'h0012_3456, -1, 1'b1, 1'b1);
        send_frame(1'b0);
        get_credit("b2b.first", 2'b01, 1'b1, 2'd2, 32'h0012_3456, 1'b0, 1'b0, 1'b1);
        build_frame(1, 32'h0000_A5A5, -1, 1'b1, 1'b0);
        send_frame(1'b0);
        get_credit("b2b.second", 2'b01, 1'b1, 2'd1, 32'h0000_A5A5, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of the data slots aborts the frame silently.
        build_frame(2, 32'h00AB_CDEF, -1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus_in = frame_q[i];
        end
        @(negedge clk);
        rstn   = 1'b0;
        bus_in = 1'b1;
        @(negedge clk);
        chk("rstmid.credit", 64'(credit_out), 64'd1);
        chk("rstmid.valid", 64'(msg_valid_o), 64'd0);
`ifdef EBI_RX_ERR_CNT_EN
        chk("rstmid.cnt_parity", 64'(parity_err_cnt_o), 64'd0);
`endif
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid.quiet%0d", i), 64'(credit_out), 64'd1);
        end
        build_frame(0, 32'h0000_003C, -1, 1'b1, 1'b1);
        send_frame(1'b0);
        get_credit("rstmid.after", 2'b01, 1'b1, 2'd0, 32'h0000_003C, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
